// File: rtl/xor4_pipe_if.sv
// Handshake bundle for xor4_pipe: producer side (in_*, a, b) and consumer side
// (out_*, x and flags). The slave modport is the block's view of the bundle.
interface xor4_pipe_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic             parity;
  logic [CNT_W-1:0] ones;
  logic             equal;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, x, parity, ones, equal
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, x, parity, ones, equal
  );
endinterface

// File: rtl/xor4_pipe.sv
// One-stage registered XOR of two operands with parity, popcount and equality
// flags, behind valid/ready handshakes on both sides.
module xor4_pipe #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  xor4_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] x_q, x_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             equal_q, equal_d;
  logic             out_valid_q, out_valid_d;

  logic             load;
  logic [WIDTH-1:0] xor_w;
  logic [CNT_W-1:0] pop_w;

  // The only combinational input-to-output path is out_ready -> in_ready.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;
  assign xor_w        = bus.a ^ bus.b;

  always_comb begin
    pop_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_w = pop_w + CNT_W'(xor_w[i]);
    end
  end

  always_comb begin
    x_d         = x_q;
    parity_d    = parity_q;
    ones_d      = ones_q;
    equal_d     = equal_q;
    out_valid_d = out_valid_q;
    if (load) begin
      x_d         = xor_w;
      parity_d    = ^xor_w;
      ones_d      = pop_w;
      equal_d     = (xor_w == '0);
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      // Result consumed with nothing new behind it; data holds, only valid drops.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q         <= '0;
      parity_q    <= 1'b0;
      ones_q      <= '0;
      equal_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      parity_q    <= parity_d;
      ones_q      <= ones_d;
      equal_q     <= equal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.parity    = parity_q;
  assign bus.ones      = ones_q;
  assign bus.equal     = equal_q;
endmodule

// File: tb/tb_xor4_pipe.sv
// Directed-vector bench for xor4_pipe: reset, single results, flag corners,
// backpressure, streaming and reset while a result is pending.
module tb_xor4_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  xor4_pipe_if #(.WIDTH(4)) bus ();

  xor4_pipe #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.x !== 4'h0 || bus.ones !== 3'd0 ||
        bus.parity !== 1'b0 || bus.equal !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: got out_valid=%b x=%h ones=%0d parity=%b equal=%b in_ready=%b want 0 0 0 0 0 1",
               bus.out_valid, bus.x, bus.ones, bus.parity, bus.equal, bus.in_ready);
    end
    $display("reset: out_valid=%b x=%h ones=%0d in_ready=%b", bus.out_valid, bus.x, bus.ones, bus.in_ready);
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = 4'b0011;
    bus.b = 4'd5;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.x !== 4'b0110 || bus.parity !== 1'b0 ||
        bus.ones !== 3'd2 || bus.equal !== 1'b0) begin
      errors++;
      $display("FAIL basic: got v=%b x=%b p=%b ones=%0d eq=%b want 1 0110 0 2 0",
               bus.out_valid, bus.x, bus.parity, bus.ones, bus.equal);
    end
    $display("basic: a=0011 b=0101 -> x=%b p=%b ones=%0d eq=%b", bus.x, bus.parity, bus.ones, bus.equal);
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.x !== 4'b0110 || bus.ones !== 3'd2) begin
      errors++;
      $display("FAIL drain_hold: got v=%b x=%b ones=%0d want 0 0110 2", bus.out_valid, bus.x, bus.ones);
    end
    $display("drain: out_valid=%b x=%b held", bus.out_valid, bus.x);
  endtask

  task automatic test_patterns();
    logic [3:0] va [4] = '{4'h0, 4'hF, 4'h1, 4'hC};
    logic [3:0] vb [4] = '{4'h0, 4'h0, 4'h0, 4'hC};
    logic [3:0] ex [4] = '{4'h0, 4'hF, 4'h1, 4'h0};
    logic       ep [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] eo [4] = '{3'd0, 3'b100, 3'd1, 3'd0};
    logic       ee [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.a = va[i];
      bus.b = vb[i];
      step();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.x !== ex[i] || bus.parity !== ep[i] ||
          bus.ones !== eo[i] || bus.equal !== ee[i]) begin
        errors++;
        $display("FAIL pattern%0d: got v=%b x=%h p=%b ones=%0d eq=%b want 1 %h %b %0d %b",
                 i, bus.out_valid, bus.x, bus.parity, bus.ones, bus.equal, ex[i], ep[i], eo[i], ee[i]);
      end
      $display("pattern%0d: a=%h b=%h -> x=%h p=%b ones=%0d eq=%b",
               i, va[i], vb[i], bus.x, bus.parity, bus.ones, bus.equal);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [3:0] noise [3] = '{4'h7, 4'hE, 4'h2};
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 4'h9;
    bus.b = 4'h3;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.x !== 4'hA || bus.ones !== 3'd2 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_load: got v=%b x=%h ones=%0d rdy=%b want 1 a 2 0",
               bus.out_valid, bus.x, bus.ones, bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      bus.a = (i == 1) ? 4'bxxxx : noise[i];
      bus.b = 4'h5;
      step();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.x !== 4'hA ||
          bus.parity !== 1'b0 || bus.ones !== 3'd2 || bus.equal !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b x=%h p=%b ones=%0d eq=%b want 0 1 a 0 2 0",
                 i, bus.in_ready, bus.out_valid, bus.x, bus.parity, bus.ones, bus.equal);
      end
      $display("bp cycle %0d: in_ready=%b x=%h held", i, bus.in_ready, bus.x);
    end
    bus.a = 4'h6;
    bus.b = 4'h3;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got in_ready=%b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.x !== 4'h5 || bus.ones !== 3'd2 || bus.parity !== 1'b0) begin
      errors++;
      $display("FAIL bp_next: got v=%b x=%h ones=%0d p=%b want 1 5 2 0",
               bus.out_valid, bus.x, bus.ones, bus.parity);
    end
    $display("bp release: next x=%h", bus.x);
    step();
  endtask

  task automatic test_streaming();
    logic [3:0] sa, sb, sx;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sa = 4'(i);
      sb = 4'((i * 7 + 3) & 15);
      sx = sa ^ sb;
      bus.a = sa;
      bus.b = sb;
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.x !== sx || bus.ones !== 3'($countones(sx)) ||
          bus.parity !== ^sx || bus.equal !== (sx == 4'h0)) begin
        errors++;
        $display("FAIL stream%0d: got v=%b x=%h ones=%0d p=%b eq=%b want 1 %h %0d %b %b",
                 i, bus.out_valid, bus.x, bus.ones, bus.parity, bus.equal,
                 sx, $countones(sx), ^sx, (sx == 4'h0));
      end
      $display("stream%0d: a=%h b=%h -> x=%h", i, sa, sb, bus.x);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 4'h7;
    bus.b = 4'h1;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.x !== 4'h6) begin
      errors++;
      $display("FAIL mid_load: got v=%b x=%h want 1 6", bus.out_valid, bus.x);
    end
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = 4'hF;
    bus.b = 4'h0;
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.x !== 4'h0 || bus.ones !== 3'd0 ||
        bus.equal !== 1'b0 || bus.parity !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b x=%h ones=%0d eq=%b p=%b want 0 0 0 0 0",
               bus.out_valid, bus.x, bus.ones, bus.equal, bus.parity);
    end
    $display("reset mid-op: out_valid=%b x=%h", bus.out_valid, bus.x);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 4'h0;
    bus.b = 4'h0;
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
